// File: rtl/shift_chain_pkg.sv
// Shared types and sizing helpers for the shift-chain driver family.
package shift_chain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HIGH  = 2'd2,
      LATCH = 2'd3
   } state_e;

   function automatic int frame_bits(input int n_bytes);
      return 8 * n_bytes;
   endfunction

   // Bits needed to hold the values 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-CLK_DIV counter producing a one-cycle tick on its last count.
module tick_divider
   import shift_chain_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tick
);

   localparam int DW = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] count_q;
   logic [DW-1:0] count_d;

   // Next count: clear wins, otherwise wrap at LAST while enabled.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = {DW{1'b0}};
      end else if (i_en) begin
         if (count_q == LAST) begin
            count_d = {DW{1'b0}};
         end else begin
            count_d = count_q + DW'(1);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {DW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign o_tick = i_en & (count_q == LAST);

endmodule

// File: rtl/shift_chain_driver.sv
// Serial driver for a chain of 74HC595-style registers: parallel frame in, DS/SHCP/STCP out.
// A one-entry holding buffer lets the next frame start on the same edge the current one latches.
module shift_chain_driver
   import shift_chain_pkg::*;
#(
   parameter int N_BYTES   = 3,
   parameter int CLK_DIV   = 4,
   parameter int LSB_FIRST = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*N_BYTES-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_STCP,
   output logic                 o_SHCP,
   output logic                 o_DS
);

   localparam int FB = frame_bits(N_BYTES);
   localparam int CW = cnt_width(FB + 1);

   state_e          state_q, state_d;
   logic [FB-1:0]   shift_q, shift_d;
   logic [FB-1:0]   hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [CW-1:0]   bitcnt_q, bitcnt_d;
   logic            shcp_q, shcp_d;
   logic            stcp_q, stcp_d;
   logic            ds_q, ds_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;

   logic            accept_s;
   logic            capture_s;
   logic            tick_s;
   logic            div_en_s;
   logic            div_clear_s;
   logic [FB-1:0]   load_frame_s;

   function automatic logic first_bit(input logic [FB-1:0] v);
      if (LSB_FIRST != 0) begin
         return v[0];
      end else begin
         return v[FB-1];
      end
   endfunction

   function automatic logic [FB-1:0] advance(input logic [FB-1:0] v);
      if (LSB_FIRST != 0) begin
         return {1'b0, v[FB-1:1]};
      end else begin
         return {v[FB-2:0], 1'b0};
      end
   endfunction

   assign accept_s     = i_valid & ~hold_full_q;
   assign div_en_s     = (state_q != IDLE);
   // A frame arriving on the latch-completing edge goes straight to the shifter, not the buffer.
   assign capture_s    = accept_s & (state_q != IDLE) & ~((state_q == LATCH) & tick_s);
   assign load_frame_s = hold_full_q ? hold_q : i_data;

   tick_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .i_clear (div_clear_s),
      .i_en    (div_en_s),
      .o_tick  (tick_s)
   );

   // Frame FSM: SETUP/HIGH alternate per bit, LATCH pulses STCP, then reload or go idle.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bitcnt_d    = bitcnt_q;
      shcp_d      = shcp_q;
      stcp_d      = stcp_q;
      ds_d        = ds_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      div_clear_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               shift_d     = load_frame_s;
               bitcnt_d    = CW'(FB);
               ds_d        = first_bit(load_frame_s);
               busy_d      = 1'b1;
               div_clear_s = 1'b1;
               state_d     = SETUP;
            end else begin
               busy_d = 1'b0;
            end
         end
         SETUP: begin
            if (tick_s) begin
               shcp_d  = 1'b1;
               state_d = HIGH;
            end else begin
               shcp_d = 1'b0;
            end
         end
         HIGH: begin
            if (tick_s) begin
               shcp_d   = 1'b0;
               shift_d  = advance(shift_q);
               bitcnt_d = bitcnt_q - CW'(1);
               if (bitcnt_q == CW'(1)) begin
                  stcp_d  = 1'b1;
                  state_d = LATCH;
               end else begin
                  ds_d    = first_bit(advance(shift_q));
                  state_d = SETUP;
               end
            end else begin
               shcp_d = 1'b1;
            end
         end
         LATCH: begin
            if (tick_s) begin
               stcp_d = 1'b0;
               done_d = 1'b1;
               if (hold_full_q || accept_s) begin
                  shift_d     = load_frame_s;
                  bitcnt_d    = CW'(FB);
                  ds_d        = first_bit(load_frame_s);
                  hold_full_d = 1'b0;
                  state_d     = SETUP;
               end else begin
                  ds_d    = 1'b0;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               stcp_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            shcp_d  = 1'b0;
            stcp_d  = 1'b0;
            ds_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
      if (capture_s) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end else begin
         hold_d = hold_q;
      end
      ready_d = ~hold_full_d;
   end

   // State and output registers; reset aborts any frame without pulsing STCP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= {FB{1'b0}};
         hold_q      <= {FB{1'b0}};
         hold_full_q <= 1'b0;
         bitcnt_q    <= {CW{1'b0}};
         shcp_q      <= 1'b0;
         stcp_q      <= 1'b0;
         ds_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bitcnt_q    <= bitcnt_d;
         shcp_q      <= shcp_d;
         stcp_q      <= stcp_d;
         ds_q        <= ds_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_STCP  = stcp_q;
   assign o_SHCP  = shcp_q;
   assign o_DS    = ds_q;

endmodule

// File: tb/tb_shift_chain_driver.sv
// Directed bench: single frames from a vector table on three configurations, plus
// back-to-back buffering and mid-frame reset sequences.
module tb_shift_chain_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] data0, data1;
   logic [7:0]  data2;
   logic        valid [3];
   logic        ready [3];
   logic        busy  [3];
   logic        done  [3];
   logic        stcp  [3];
   logic        shcp  [3];
   logic        ds    [3];

   always #5 clk = ~clk;

   shift_chain_driver #(.N_BYTES(3), .CLK_DIV(4), .LSB_FIRST(0)) u0 (
      .clk(clk), .rst(rst), .i_data(data0), .i_valid(valid[0]), .o_ready(ready[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_STCP(stcp[0]), .o_SHCP(shcp[0]), .o_DS(ds[0]));
   shift_chain_driver #(.N_BYTES(3), .CLK_DIV(4), .LSB_FIRST(1)) u1 (
      .clk(clk), .rst(rst), .i_data(data1), .i_valid(valid[1]), .o_ready(ready[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_STCP(stcp[1]), .o_SHCP(shcp[1]), .o_DS(ds[1]));
   shift_chain_driver #(.N_BYTES(1), .CLK_DIV(1), .LSB_FIRST(0)) u2 (
      .clk(clk), .rst(rst), .i_data(data2), .i_valid(valid[2]), .o_ready(ready[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_STCP(stcp[2]), .o_SHCP(shcp[2]), .o_DS(ds[2]));

   typedef struct {
      int          sel;
      logic [23:0] data;
      logic [63:0] exp_cap;
      int          nbits;
      int          lat;
      int          cdiv;
   } vec_t;

   vec_t vecs [6];

   int errors = 0;
   int checks = 0;

   int          rises, hi_min, hi_max, hi_run, st_run, stcp_rises, stcp_w;
   int          stcp_rise_k, last_fall_k, n_done, busy_lo, ready_hi;
   int          done_k [4];
   logic        rdy_at_done0;
   logic [63:0] cap;
   logic        prev_shcp, prev_stcp;
   logic        s_shcp, s_stcp, s_ds, s_busy, s_done, s_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic [23:0] d, input logic v);
      case (sel)
         0: begin data0 = d; valid[0] = v; end
         1: begin data1 = d; valid[1] = v; end
         2: begin data2 = d[7:0]; valid[2] = v; end
         default: ;
      endcase
   endtask

   task automatic clear_stats();
      rises = 0; hi_min = 1000; hi_max = 0; hi_run = 0; st_run = 0;
      stcp_rises = 0; stcp_w = 0; stcp_rise_k = -1; last_fall_k = -2;
      n_done = 0; busy_lo = 0; ready_hi = 0; rdy_at_done0 = 1'b0; cap = 64'd0;
      prev_shcp = 1'b0; prev_stcp = 1'b0;
      for (int i = 0; i < 4; i++) done_k[i] = -1;
   endtask

   // One clock: sample the selected DUT 1 time unit after the edge and update statistics.
   task automatic step(input int sel, input int k);
      @(posedge clk);
      #1;
      s_shcp = shcp[sel]; s_stcp = stcp[sel]; s_ds = ds[sel];
      s_busy = busy[sel]; s_done = done[sel]; s_ready = ready[sel];
      if (s_shcp && !prev_shcp) begin
         rises++;
         cap = {cap[62:0], s_ds};
         hi_run = 1;
      end else if (s_shcp) begin
         hi_run++;
      end
      if (!s_shcp && prev_shcp) begin
         if (hi_run < hi_min) hi_min = hi_run;
         if (hi_run > hi_max) hi_max = hi_run;
         last_fall_k = k;
      end
      if (s_stcp && !prev_stcp) begin
         stcp_rises++;
         stcp_rise_k = k;
         st_run = 1;
      end else if (s_stcp) begin
         st_run++;
      end
      if (!s_stcp && prev_stcp) stcp_w = st_run;
      if (!s_busy && !s_done) busy_lo++;
      if (s_ready) ready_hi++;
      if (s_done) begin
         if (n_done == 0) rdy_at_done0 = s_ready;
         if (n_done < 4) done_k[n_done] = k;
         n_done++;
      end
      prev_shcp = s_shcp;
      prev_stcp = s_stcp;
   endtask

   task automatic run_vec(input vec_t v);
      drive(v.sel, v.data, 1'b1);
      clear_stats();
      step(v.sel, 0);
      drive(v.sel, v.data, 1'b0);
      chk("busy_at_accept", s_busy, 1);
      chk("first_ds", s_ds, v.exp_cap[v.nbits-1]);
      for (int k = 1; k <= v.lat + 20; k++) begin
         if (n_done != 0) break;
         step(v.sel, k);
      end
      chk("done_latency", done_k[0], v.lat);
      chk("shcp_rises", rises, v.nbits);
      chk("ds_sequence", cap, v.exp_cap);
      chk("shcp_high_min", hi_min, v.cdiv);
      chk("shcp_high_max", hi_max, v.cdiv);
      chk("stcp_pulses", stcp_rises, 1);
      chk("stcp_width", stcp_w, v.cdiv);
      chk("stcp_after_last_fall", stcp_rise_k, last_fall_k);
      chk("idle_outs", {s_busy, s_ds, s_shcp, s_stcp}, 4'b0000);
      chk("idle_ready", s_ready, 1);
      step(v.sel, v.lat + 1);
      chk("done_one_cycle", s_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 24'hA5C30F, 64'h0000_0000_00A5_C30F, 24, 196, 4};
      vecs[1] = '{0, 24'h800001, 64'h0000_0000_0080_0001, 24, 196, 4};
      vecs[2] = '{1, 24'hA5C30F, 64'h0000_0000_00F0_C3A5, 24, 196, 4};
      vecs[3] = '{1, 24'h000001, 64'h0000_0000_0080_0000, 24, 196, 4};
      vecs[4] = '{2, 24'h000081, 64'h0000_0000_0000_0081, 8, 17, 1};
      vecs[5] = '{2, 24'h0000C4, 64'h0000_0000_0000_00C4, 8, 17, 1};

      rst = 1'b1;
      data0 = 24'd0; data1 = 24'd0; data2 = 8'd0;
      for (int i = 0; i < 3; i++) valid[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_outs", {stcp[i], shcp[i], ds[i], busy[i], done[i]}, 5'b00000);
         chk("reset_ready", ready[i], 1);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Back-to-back: second frame buffered, third frame refused while buffer full.
      drive(0, 24'h000001, 1'b1);
      clear_stats();
      step(0, 0);
      drive(0, 24'hFFFFFF, 1'b1);
      step(0, 1);
      chk("b2b_ready_drop", s_ready, 0);
      drive(0, 24'h5A5A5A, 1'b1);
      ready_hi = 0;
      for (int k = 2; k <= 10; k++) step(0, k);
      chk("b2b_full_no_ready", ready_hi, 0);
      drive(0, 24'h5A5A5A, 1'b0);
      for (int k = 11; k <= 500; k++) begin
         if (n_done >= 2) break;
         step(0, k);
      end
      chk("b2b_done0", done_k[0], 196);
      chk("b2b_done1", done_k[1], 392);
      chk("b2b_ready_at_done0", rdy_at_done0, 1);
      chk("b2b_no_idle_gap", busy_lo, 0);
      chk("b2b_rises", rises, 48);
      chk("b2b_ds_sequence", cap, 64'h0000_0000_01FF_FFFF);
      for (int k = 393; k <= 460; k++) step(0, k);
      chk("b2b_only_two_dones", n_done, 2);
      chk("b2b_only_two_frames", rises, 48);

      // Reset in the middle of a frame.
      drive(0, 24'hA5C30F, 1'b1);
      clear_stats();
      step(0, 0);
      drive(0, 24'hA5C30F, 1'b0);
      for (int k = 1; k <= 50; k++) step(0, k);
      chk("mid_busy_before_rst", s_busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {stcp[0], shcp[0], ds[0], busy[0], done[0]}, 5'b00000);
      chk("mid_rst_ready", ready[0], 1);
      chk("mid_no_stcp", stcp_rises, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stats();
      for (int k = 0; k < 5; k++) step(0, k);
      chk("post_rst_idle", {s_busy, s_stcp, s_shcp}, 3'b000);
      chk("post_rst_ready", s_ready, 1);
      run_vec('{0, 24'h123456, 64'h0000_0000_0012_3456, 24, 196, 4});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_chain_driver.md
Name: shift_chain_driver

Overview:
Parametrised serial driver for a daisy-chain of 74HC595-style shift registers: takes an N_BYTES-wide parallel word over a valid/ready handshake and produces the DS, SHCP and STCP waveforms at a programmable bit rate.
It succeeds the fixed 8-bit shift_reg driver. It adds configurable chain length, bit order and SHCP rate, a one-entry holding buffer for back-to-back updates, and busy/done status.
Instanced once per LED bank or digit chain under the board top.

Parameters:
N_BYTES, 3, number of chained 8-bit registers; must be at least 1. Frame length is 8*N_BYTES bits.
CLK_DIV, 4, clk cycles per SHCP half-period and per STCP high time; must be at least 1.
LSB_FIRST, 0, 0 shifts i_data[8*N_BYTES-1] first; 1 shifts i_data[0] first.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_data  in  8*N_BYTES  frame to display
i_valid  in  1  frame offered
o_ready  out  1  frame accepted on a clk edge where i_valid and o_ready are both high
o_busy  out  1  a frame is being shifted or latched
o_done  out  1  one-cycle pulse when a frame has been latched
o_STCP  out  1  storage (latch) clock to the chain
o_SHCP  out  1  shift clock to the chain
o_DS  out  1  serial data to the chain

Behaviour:
- Reset (asynchronous, immediate): o_STCP, o_SHCP, o_DS, o_busy and o_done are 0. State is IDLE and the holding buffer is empty, so o_ready=1.
- Reset mid-frame aborts the transfer. STCP stays 0, so the chain outputs keep the last latched frame.
- o_ready = holding buffer empty.
- Accept while IDLE:
  - Frame is loaded into the shifter; bit counter = 8*N_BYTES; divider is cleared; next state is SETUP.
  - o_busy goes 1 on the same edge, and o_DS presents the first bit.
- Accept while not IDLE: frame is stored in the holding buffer and o_ready drops. A newer frame cannot overwrite it.
- Tick: the divider counts 0..CLK_DIV-1 while not IDLE. tick = (count == CLK_DIV-1).
- SETUP (SHCP=0, DS stable): on tick, SHCP goes 1 and the state moves to HIGH.
- HIGH (SHCP=1): on tick:
  - SHCP goes 0, the shifter advances one bit and the counter decrements.
  - If the counter reaches 0: STCP goes 1, state moves to LATCH.
  - Otherwise: DS takes the next bit, state moves to SETUP.
- LATCH (STCP=1, SHCP=0): on tick, STCP goes 0, o_done pulses, and the FSM completes.
- On completion:
  - If the holding buffer is full: its frame loads into the shifter in the same edge, state goes to SETUP, o_busy stays 1, and the buffer empties so o_ready rises.
  - Otherwise: state goes to IDLE, o_busy=0 and o_DS=0.
- Latency: o_done is asserted exactly (16*N_BYTES+1)*CLK_DIV cycles after the accepting edge. Chained frames are spaced by the same period.
- Bit order: with LSB_FIRST=0, the MSB of the top byte is sent first, so it lands in the farthest register. LSB_FIRST=1 mirrors this.
- Widths:
  - Bit counter is $clog2(8*N_BYTES+1) bits.
  - Divider is $clog2(CLK_DIV) bits, minimum 1.
  - With CLK_DIV=1 every cycle is a tick.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package shift_chain_pkg holds:
  - state enum: IDLE, SETUP, HIGH, LATCH;
  - function for frame length, FRAME_BITS = 8*N_BYTES;
  - counter-width helper.
- Sub-module tick_divider(clk, rst, i_clear, i_en, o_tick), parametrised by CLK_DIV. It is reusable by the digit-view driver.

Test Plan:
- N_BYTES=3, CLK_DIV=4, LSB_FIRST=0, i_data=24'hA5C30F, single pulse:
  - capture DS on each SHCP rise: sequence is A5,C3,0F MSB-first;
  - 24 SHCP rises, each SHCP half-period 4 clk;
  - one STCP pulse 4 clk wide after the last SHCP fall;
  - o_done 196 cycles after accept.
- Same frame with LSB_FIRST=1 -> DS sequence is 0F,C3,A5 bit-reversed, starting with bit 0 = 1.
- i_valid held high with 24'h000001 then 24'hFFFFFF presented during busy:
  - o_ready drops after the second accept and rises at the first o_done;
  - second frame starts with no IDLE gap;
  - two o_done pulses 196 cycles apart.
- Third frame offered while the buffer is full -> o_ready=0, no accept; only two frames shifted.
- rst asserted at cycle 50 of a frame -> all outputs 0 immediately, no STCP pulse, o_ready=1 after release. A new frame of 24'h123456 then completes normally.
- N_BYTES=1, CLK_DIV=1, i_data=8'h81 -> SHCP toggles every cycle; DS = 1,0,0,0,0,0,0,1; o_done 17 cycles after accept.
